// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the UART receiver and the command parser: level/pulse
// pop handshake, fill level, and sticky overflow with a saturating drop counter.
module uart_rx_fifo #(
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          out_rdy,
   output logic [7:0]    out_data,
   input  logic          out_rdy_clr,
   output logic [AW:0]   level,
   output logic          full,
   output logic          overflow,
   output logic [7:0]    drop_cnt,
   input  logic          overflow_clr
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   level_reg, level_next;
   logic          overflow_reg, overflow_next;
   logic [7:0]    drop_cnt_reg, drop_cnt_next;

   logic [AW-1:0] wr_idx, rd_idx;
   logic          empty, full_ptr;
   logic          push, pop, drop;

   assign wr_idx   = wr_ptr_reg[AW-1:0];
   assign rd_idx   = rd_ptr_reg[AW-1:0];
   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full_ptr = (wr_idx == rd_idx) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign pop  = out_rdy_clr && !empty;
   assign push = in_valid && (!full_ptr || pop);
   assign drop = in_valid && full_ptr && !pop;

   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + 1'b1;
         2'b01:   level_next = level_reg - 1'b1;
         default: level_next = level_reg;
      endcase
   end

   // A drop coincident with a clear wins: the counter restarts at one.
   always_comb begin
      overflow_next = overflow_reg;
      drop_cnt_next = drop_cnt_reg;
      if (drop) begin
         overflow_next = 1'b1;
         if (overflow_clr)
            drop_cnt_next = 8'h01;
         else if (drop_cnt_reg != 8'hFF)
            drop_cnt_next = drop_cnt_reg + 8'h01;
      end else if (overflow_clr) begin
         overflow_next = 1'b0;
         drop_cnt_next = 8'h00;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
         drop_cnt_reg <= 8'h00;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         level_reg    <= level_next;
         overflow_reg <= overflow_next;
         drop_cnt_reg <= drop_cnt_next;
      end
   end

   // Storage holds no reset; stale contents are masked by the pointers.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_idx] <= in_data;
   end

   assign out_data = empty ? 8'h00 : mem[rd_idx];
   assign out_rdy  = (level_reg != '0);
   assign full     = (level_reg == DEPTH_L);
   assign level    = level_reg;
   assign overflow = overflow_reg;
   assign drop_cnt = drop_cnt_reg;

endmodule
